rsa_job_sequencer: RTL and testbench

- Initiator side of the RSA `control` core interface; owns the job sequence the core expects.
- Sequence per job:
  - Accept a job over a valid/ready port.
  - Drive p/q/mode/message to the core.
  - Pulse `reset_inverter`, then wait for `inverter_finish`.
  - Pulse `reset_mod_exp`, then wait for `mod_exp_finish`.
  - Capture `msg_out` and present it on a valid/ready result port.
- Sits between a host or DMA front end and one `control` instance. Two sequencers can be chained for encrypt-then-decrypt.

---
 rtl/rsa_job_sequencer.sv | 176 +++++++++++++++++
 tb/tb_rsa_job_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_job_sequencer.sv
// Job sequencer driving one RSA control core: accepts a job, pulses the inverter and
// mod-exp resets in turn, waits for each armed finish and returns the result.
//
// state     | meaning
// IDLE      | waiting for a job; job_ready high
// INV_PULSE | core_reset_inverter high for PULSE_LEN cycles
// INV_WAIT  | waiting for an armed core_inverter_finish
// EXP_PULSE | core_reset_mod_exp high for PULSE_LEN cycles
// EXP_WAIT  | waiting for an armed core_mod_exp_finish
// DONE      | result held on res_* until res_ready
module rsa_job_sequencer #(
    parameter int WIDTH     = 128,
    parameter int PULSE_LEN = 1,
    parameter int TIMEOUT   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [WIDTH-1:0]     job_p,
    input  logic [WIDTH-1:0]     job_q,
    input  logic                 job_mode,
    input  logic [2*WIDTH-1:0]   job_msg,
    output logic [WIDTH-1:0]     core_p,
    output logic [WIDTH-1:0]     core_q,
    output logic                 core_mode,
    output logic [2*WIDTH-1:0]   core_msg,
    output logic                 core_reset_inverter,
    output logic                 core_reset_mod_exp,
    input  logic                 core_inverter_finish,
    input  logic                 core_mod_exp_finish,
    input  logic [2*WIDTH-1:0]   core_msg_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_msg,
    output logic                 res_mode,
    output logic                 res_err,
    output logic                 busy,
    output logic [15:0]          job_count
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [3:0]    PULSE_LOAD = 4'(PULSE_LEN - 1);
    localparam logic [TW-1:0] WD_LOAD    = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INV_PULSE,
        S_INV_WAIT,
        S_EXP_PULSE,
        S_EXP_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    pulse_cnt;
    logic [TW-1:0] wd_cnt;
    logic          armed;
    logic          inv_go;
    logic          exp_go;
    logic          wd_expired;

    // A finish only counts once it has been seen low after the pulse, so a level
    // left high by the previous job cannot complete the current one.
    assign inv_go     = core_inverter_finish && armed;
    assign exp_go     = core_mod_exp_finish && armed;
    assign wd_expired = (TIMEOUT != 0) && (wd_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        job_ready           = 1'b0;
        busy                = 1'b1;
        res_valid           = 1'b0;
        core_reset_inverter = 1'b0;
        core_reset_mod_exp  = 1'b0;
        case (state)
            S_IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
                if (job_valid) state_nxt = S_INV_PULSE;
            end
            S_INV_PULSE: begin
                core_reset_inverter = 1'b1;
                if (pulse_cnt == '0) state_nxt = S_INV_WAIT;
            end
            S_INV_WAIT: begin
                if (inv_go)          state_nxt = S_EXP_PULSE;
                else if (wd_expired) state_nxt = S_DONE;
            end
            S_EXP_PULSE: begin
                core_reset_mod_exp = 1'b1;
                if (pulse_cnt == '0) state_nxt = S_EXP_WAIT;
            end
            S_EXP_WAIT: begin
                if (exp_go || wd_expired) state_nxt = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_p    <= '0;
            core_q    <= '0;
            core_mode <= 1'b0;
            core_msg  <= '0;
            res_msg   <= '0;
            res_mode  <= 1'b0;
            res_err   <= 1'b0;
            job_count <= '0;
            pulse_cnt <= '0;
            wd_cnt    <= '0;
            armed     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        core_p    <= job_p;
                        core_q    <= job_q;
                        core_mode <= job_mode;
                        core_msg  <= job_msg;
                        pulse_cnt <= PULSE_LOAD;
                        armed     <= 1'b0;
                    end
                end
                S_INV_PULSE, S_EXP_PULSE: begin
                    if (pulse_cnt == '0) wd_cnt <= WD_LOAD;
                    else                 pulse_cnt <= pulse_cnt - 4'd1;
                end
                S_INV_WAIT: begin
                    if (!core_inverter_finish) armed <= 1'b1;
                    if (inv_go) begin
                        pulse_cnt <= PULSE_LOAD;
                        armed     <= 1'b0;
                    end else if (wd_expired) begin
                        res_msg  <= '0;
                        res_mode <= core_mode;
                        res_err  <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end
                S_EXP_WAIT: begin
                    if (!core_mod_exp_finish) armed <= 1'b1;
                    if (exp_go) begin
                        res_msg  <= core_msg_out;
                        res_mode <= core_mode;
                        res_err  <= 1'b0;
                    end else if (wd_expired) begin
                        res_msg  <= '0;
                        res_mode <= core_mode;
                        res_err  <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) job_count <= job_count + 16'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Bench for rsa_job_sequencer: behavioural core model on the negative edge, table of
// directed jobs, randomized jobs, and hand-written reset / counter-wrap sequences.
module tb_rsa_job_sequencer;
    localparam int W  = 128;
    localparam int MW = 2 * W;
    localparam int PL = 3;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          reset;
    logic          job_valid, job_ready, job_mode;
    logic [W-1:0]  job_p, job_q, core_p, core_q;
    logic [MW-1:0] job_msg, core_msg, core_msg_out, res_msg;
    logic          core_mode, core_reset_inverter, core_reset_mod_exp;
    logic          core_inverter_finish, core_mod_exp_finish;
    logic          res_valid, res_ready, res_mode, res_err, busy;
    logic [15:0]   job_count;

    rsa_job_sequencer #(.WIDTH(W), .PULSE_LEN(PL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_p(job_p), .job_q(job_q), .job_mode(job_mode), .job_msg(job_msg),
        .core_p(core_p), .core_q(core_q), .core_mode(core_mode), .core_msg(core_msg),
        .core_reset_inverter(core_reset_inverter), .core_reset_mod_exp(core_reset_mod_exp),
        .core_inverter_finish(core_inverter_finish), .core_mod_exp_finish(core_mod_exp_finish),
        .core_msg_out(core_msg_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_msg(res_msg),
        .res_mode(res_mode), .res_err(res_err), .busy(busy), .job_count(job_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check_vec(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Stand-in for the control core: a reversible transform so encrypt-then-decrypt round-trips.
    function automatic logic [MW-1:0] core_fn(input logic [W-1:0] p, input logic [W-1:0] q,
                                              input logic [MW-1:0] msg);
        return msg ^ (MW'(p) * MW'(q));
    endfunction

    function automatic logic [W-1:0] rand_w();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Core model configuration (written only by the stimulus process)
    int inv_delay = 20, exp_delay = 20;
    bit stale = 1'b0, exp_never = 1'b0;

    // Core model state and monitors (written only by the negedge process)
    logic inv_fin = 1'b0, exp_fin = 1'b0;
    int inv_t = -1, exp_t = -1, inv_w = 0, exp_w = 0, ncyc = 0;
    int inv_pulses = 0, exp_pulses = 0, wbad = 0, overlap = 0;
    int inv_rise = -1, exp_rise = -1, exp_start = -1, exp_end = -1;

    assign core_inverter_finish = inv_fin;
    assign core_mod_exp_finish  = exp_fin;
    assign core_msg_out         = exp_fin ? core_fn(core_p, core_q, core_msg) : '1;

    always @(negedge clk) begin
        ncyc++;
        if (core_reset_inverter && core_reset_mod_exp) overlap++;
        if (core_reset_inverter) begin
            if (inv_w == 0) inv_pulses++;
            inv_w++;
            inv_t = 0;
            if (!stale) inv_fin = 1'b0;
        end else begin
            if (inv_w != 0 && inv_w != PL) wbad++;
            inv_w = 0;
            if (inv_t >= 0) begin
                inv_t++;
                if (stale && inv_t == 3) inv_fin = 1'b0;
                else if (inv_t >= inv_delay) begin
                    inv_fin  = 1'b1;
                    inv_rise = ncyc;
                    inv_t    = -1;
                end
            end
        end
        if (core_reset_mod_exp) begin
            if (exp_w == 0) begin
                exp_pulses++;
                exp_start = ncyc;
            end
            exp_w++;
            exp_end = ncyc;
            exp_t   = 0;
            exp_fin = 1'b0;
        end else begin
            if (exp_w != 0 && exp_w != PL) wbad++;
            exp_w = 0;
            if (exp_t >= 0) begin
                exp_t++;
                if (!exp_never && exp_t >= exp_delay) begin
                    exp_fin  = 1'b1;
                    exp_rise = ncyc;
                    exp_t    = -1;
                end
            end
        end
    end

    typedef struct {
        logic [W-1:0]  p;
        logic [W-1:0]  q;
        logic          mode;
        logic [MW-1:0] msg;
        int            inv_d;
        int            exp_d;
        bit            stale;
        bit            never;
        int            hold;
        bit            err;
    } vec_t;

    logic [15:0] exp_count = 16'd0;

    task automatic do_job(input vec_t v, input string tag, output logic [MW-1:0] got);
        logic [MW-1:0] exp_msg, held;
        int n, hold_bad, bp_bad, s_inv, s_exp, s_wbad, s_ovl;
        exp_msg = v.err ? '0 : core_fn(v.p, v.q, v.msg);
        @(posedge clk); #1;
        inv_delay = v.inv_d; exp_delay = v.exp_d; stale = v.stale; exp_never = v.never;
        s_inv = inv_pulses; s_exp = exp_pulses; s_wbad = wbad; s_ovl = overlap;
        job_p = v.p; job_q = v.q; job_mode = v.mode; job_msg = v.msg; job_valid = 1'b1;
        check_bit({tag, " job_ready idle"}, job_ready, 1'b1);
        @(posedge clk); #1;
        job_valid = 1'b0;
        job_p = rand_w(); job_q = rand_w(); job_mode = ~v.mode; job_msg = {rand_w(), rand_w()};
        check_vec({tag, " core_pq"}, {core_p, core_q}, {v.p, v.q});
        check_vec({tag, " core_msg"}, core_msg, v.msg);
        check_bit({tag, " busy"}, busy, 1'b1);
        n = 0;
        hold_bad = 0;
        while (!res_valid && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (core_p !== v.p || core_q !== v.q || core_msg !== v.msg || core_mode !== v.mode)
                hold_bad++;
        end
        check_bit({tag, " res_valid"}, res_valid, 1'b1);
        check_int({tag, " core data held"}, hold_bad, 0);
        check_vec({tag, " res_msg"}, res_msg, exp_msg);
        check_bit({tag, " res_mode"}, res_mode, v.mode);
        check_bit({tag, " res_err"}, res_err, v.err);
        check_int({tag, " inv pulses"}, inv_pulses - s_inv, 1);
        check_int({tag, " exp pulses"}, exp_pulses - s_exp, 1);
        check_int({tag, " pulse width/overlap"}, (wbad - s_wbad) + (overlap - s_ovl), 0);
        check_int({tag, " exp after armed inv finish"}, exp_start, inv_rise + 1);
        if (v.never) check_int({tag, " watchdog cycles"}, ncyc - exp_end, TO);
        else         check_int({tag, " done after exp finish"}, ncyc, exp_rise);
        held = res_msg;
        bp_bad = 0;
        if (v.hold > 0) begin
            job_valid = 1'b1;
            job_p = rand_w();
        end
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b1 || res_msg !== held || res_err !== v.err || job_ready !== 1'b0 ||
                job_count !== exp_count || core_p !== v.p)
                bp_bad++;
        end
        job_valid = 1'b0;
        check_int({tag, " backpressure hold"}, bp_bad, 0);
        got = res_msg;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        check_vec({tag, " job_count"}, MW'(job_count), MW'(exp_count));
        check_bit({tag, " res_valid drop"}, res_valid, 1'b0);
        check_bit({tag, " job_ready back"}, job_ready, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check_bit({tag, " job_ready"}, job_ready, 1'b1);
        check_bit({tag, " busy"}, busy, 1'b0);
        check_bit({tag, " res_valid"}, res_valid, 1'b0);
        check_vec({tag, " pulses"}, MW'({core_reset_inverter, core_reset_mod_exp}), '0);
        check_vec({tag, " core_pq"}, {core_p, core_q}, '0);
        check_vec({tag, " core_msg/mode"}, core_msg ^ MW'(core_mode), '0);
        check_vec({tag, " res_msg"}, res_msg, '0);
        check_vec({tag, " res_mode/err/count"}, MW'({res_mode, res_err, job_count}), '0);
    endtask

    vec_t          tbl[6];
    vec_t          v;
    logic [MW-1:0] got, enc;
    int            n;

    initial begin
        reset = 1'b1; job_valid = 1'b0; res_ready = 1'b0;
        job_p = '0; job_q = '0; job_mode = 1'b0; job_msg = '0;

        tbl[0] = '{p: 128'd113680897410347, q: 128'd7999808077935876437321, mode: 1'b0,
                   msg: 256'h7b2857e70000, inv_d: 20, exp_d: 20, stale: 1'b0, never: 1'b0,
                   hold: 0, err: 1'b0};
        tbl[1] = '{p: 128'd1009, q: 128'd2003, mode: 1'b1, msg: 256'h1234_5678_9abc,
                   inv_d: 4, exp_d: 6, stale: 1'b1, never: 1'b0, hold: 0, err: 1'b0};
        tbl[2] = '{p: 128'd65537, q: 128'd99991, mode: 1'b0, msg: 256'hdead_beef_cafe,
                   inv_d: 5, exp_d: 7, stale: 1'b0, never: 1'b0, hold: 10, err: 1'b0};
        tbl[3] = '{p: 128'd7919, q: 128'd104729, mode: 1'b1, msg: 256'h55aa_55aa,
                   inv_d: 3, exp_d: 3, stale: 1'b0, never: 1'b1, hold: 2, err: 1'b1};
        tbl[4] = '{p: 128'd3, q: 128'd5, mode: 1'b0, msg: {256{1'b1}},
                   inv_d: 8, exp_d: 9, stale: 1'b0, never: 1'b0, hold: 1, err: 1'b0};
        tbl[5] = '{p: {128{1'b1}}, q: 128'd2, mode: 1'b1, msg: 256'h1,
                   inv_d: 2, exp_d: 2, stale: 1'b0, never: 1'b0, hold: 0, err: 1'b0};

        #12;
        check_reset_values("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) do_job(tbl[i], $sformatf("vec%0d", i), got);

        v = '{p: 128'd8475698667747010771, q: 128'd11297384090418420749, mode: 1'b0,
              msg: 256'he3f7795eb00000000, inv_d: 20, exp_d: 20, stale: 1'b0, never: 1'b0,
              hold: 0, err: 1'b0};
        do_job(v, "rt enc", enc);
        v.mode = 1'b1;
        v.msg  = enc;
        do_job(v, "rt dec", got);
        check_vec("round trip", got, 256'he3f7795eb00000000);

        for (int i = 0; i < 8; i++) begin
            v.p     = rand_w();
            v.q     = rand_w();
            v.mode  = 1'($urandom_range(1, 0));
            v.msg   = {rand_w(), rand_w()};
            v.inv_d = $urandom_range(25, 2);
            v.exp_d = $urandom_range(25, 2);
            v.stale = 1'b0;
            v.never = ($urandom_range(5, 0) == 0);
            v.err   = v.never;
            v.hold  = $urandom_range(3, 0);
            do_job(v, $sformatf("rnd%0d", i), got);
        end

        // Reset in the middle of the mod-exp pulse
        inv_delay = 2; exp_delay = 2; stale = 1'b0; exp_never = 1'b0;
        @(posedge clk); #1;
        job_p = 128'd11; job_q = 128'd13; job_mode = 1'b1; job_msg = 256'h77; job_valid = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
        n = 0;
        while (!core_reset_mod_exp && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_bit("mid reset reached exp pulse", core_reset_mod_exp, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("mid reset");
        @(posedge clk); #1;
        reset = 1'b0;
        exp_count = 16'd0;

        // Counter wrap: preload the completed-job counter
        dut.job_count = 16'hFFFF;
        exp_count = 16'hFFFF;
        v = '{p: 128'd101, q: 128'd103, mode: 1'b0, msg: 256'hab, inv_d: 3, exp_d: 4,
              stale: 1'b0, never: 1'b0, hold: 0, err: 1'b0};
        do_job(v, "wrap", got);
        check_vec("job_count wrap", MW'(job_count), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
